// File: rtl/scan_pkg.sv
// Shared definitions for the register-file scan master: pass FSM states and
// the two pass modes. Also supplies a fallback for `WORD_LENGTH so the scan
// word width has a default when the surrounding build does not define it.
// Optional feature macro used by the RTL: SCAN_PARITY_EN.

`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package scan_pkg;

  // Pass sequencing states of the scan master
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    SHIFT   = 3'd2,
    DELIVER = 3'd3,
    DONE    = 3'd4
  } scan_state_t;

  // Pass modes as latched on an accepted start
  localparam logic SCAN_MODE_READ = 1'b0;
  localparam logic SCAN_MODE_LOAD = 1'b1;

endpackage

// File: rtl/scan_shifter.sv
// Serial engine of the scan master. Generates the clk/2 scan clock, walks
// bit_cnt through one word, drives the serial bit to the register file and
// collects the bits it returns. One word is 2*WIDTH clk cycles.
//
// Timing of the returned bits: the file presents the next bit right after
// each scan clock rising edge, and it presents bit 0 of the current register
// while frozen between words. The bit seen on the scan clock 1->0 edge of
// bit k is therefore bit k+1 of the word, and bit 0 is picked up on the edge
// that starts the word. In read mode that freshly captured bit is sent
// straight back, so every bit is rewritten with its own value and the file
// contents survive the pass.

`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module scan_shifter
  import scan_pkg::*;
#(
  parameter int WIDTH = `WORD_LENGTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             go,
  input  logic             mode,
  input  logic             ld_take,
  input  logic [WIDTH-1:0] ld_word,
  input  logic             tgt_bit,
  output logic             scan_clock,
  output logic             scan_enable,
  output logic             drive_bit,
  output logic             word_done,
  output logic [WIDTH-1:0] cap_word
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_nxt;
  logic [WIDTH-1:0] ld_reg;
  logic [WIDTH-1:0] cap_reg;
  logic             first_load_bit;

  assign bit_nxt  = bit_cnt + 1'b1;
  assign cap_word = cap_reg;

  // The last scan clock high phase of a word; the next edge ends the word
  assign word_done = scan_enable & scan_clock & (bit_cnt == LAST_BIT);

  // A word accepted in the same cycle as go has not reached ld_reg yet
  assign first_load_bit = ld_take ? ld_word[0] : ld_reg[0];

  // Hold the word being loaded for the whole shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_reg <= '0;
    end else if (ld_take) begin
      ld_reg <= ld_word;
    end
  end

  // Scan clock phase, bit counter, outgoing serial bit and capture register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_clock  <= 1'b0;
      scan_enable <= 1'b0;
      drive_bit   <= 1'b0;
      bit_cnt     <= '0;
      cap_reg     <= '0;
    end else if (clear) begin
      scan_clock  <= 1'b0;
      scan_enable <= 1'b0;
      drive_bit   <= 1'b0;
      bit_cnt     <= '0;
    end else if (go) begin
      scan_enable <= 1'b1;
      scan_clock  <= 1'b0;
      bit_cnt     <= '0;
      cap_reg[0]  <= tgt_bit;
      drive_bit   <= (mode == SCAN_MODE_LOAD) ? first_load_bit : tgt_bit;
    end else if (scan_enable) begin
      if (!scan_clock) begin
        scan_clock <= 1'b1;
      end else begin
        scan_clock <= 1'b0;
        if (bit_cnt == LAST_BIT) begin
          scan_enable <= 1'b0;
          drive_bit   <= 1'b0;
          bit_cnt     <= '0;
        end else begin
          bit_cnt          <= bit_nxt;
          cap_reg[bit_nxt] <= tgt_bit;
          drive_bit        <= (mode == SCAN_MODE_LOAD) ? ld_reg[bit_nxt] : tgt_bit;
        end
      end
    end
  end

endmodule

// File: rtl/reg_scan_ctrl.sv
// Diagnostic scan master for one register-file instance. A read pass unloads
// every register to the host stream while looping the bits back into the
// file; a load pass replaces every register with words from the host stream.
// The pass FSM, word counter and host handshakes live here, the serial
// engine lives in scan_shifter.
// Optional feature macro: SCAN_PARITY_EN (rdParity, ldParity, ldParErr).

`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module reg_scan_ctrl
  import scan_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int WIDTH = `WORD_LENGTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] rdData,
  output logic             rdValid,
  input  logic             rdReady,
  input  logic [WIDTH-1:0] ldData,
  input  logic             ldValid,
  output logic             ldReady,
  output logic             sClock,
  output logic             sEnable,
  output logic             sIn,
  input  logic             sOut
`ifdef SCAN_PARITY_EN
  ,
  output logic             rdParity,
  input  logic             ldParity,
  output logic             ldParErr
`endif
);

  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] LAST_WORD = CW'(SIZE - 1);

  scan_state_t      state;
  scan_state_t      next_state;
  logic             mode_q;
  logic [CW-1:0]    word_cnt;
  logic             last_word;
  logic             accept;
  logic             abort_hit;
  logic             go;
  logic             ld_take;
  logic             word_step;
  logic             shift_mode;
  logic             word_done;
  logic [WIDTH-1:0] cap_word;

  assign last_word = (word_cnt == LAST_WORD);
  assign accept    = (state == IDLE) && start;
  assign abort_hit = abort && (state != IDLE);

  // Transitions into SHIFT start a word; FETCH->SHIFT is a host word transfer
  assign go        = (next_state == SHIFT) && (state != SHIFT);
  assign ld_take   = (state == FETCH) && (next_state == SHIFT);
  assign word_step = ((state == SHIFT)   && (next_state == FETCH)) ||
                     ((state == DELIVER) && (next_state == SHIFT));

  // The first word of a read pass starts before mode_q has been latched
  assign shift_mode = (state == IDLE) ? mode : mode_q;

  scan_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .clear       (abort_hit),
    .go          (go),
    .mode        (shift_mode),
    .ld_take     (ld_take),
    .ld_word     (ldData),
    .tgt_bit     (sOut),
    .scan_clock  (sClock),
    .scan_enable (sEnable),
    .drive_bit   (sIn),
    .word_done   (word_done),
    .cap_word    (cap_word)
  );

  // Pass state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and handshake/status outputs; abort overrides everything
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    rdValid    = 1'b0;
    ldReady    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (mode == SCAN_MODE_LOAD) ? FETCH : SHIFT;
        end
      end
      FETCH: begin
        busy    = 1'b1;
        ldReady = 1'b1;
        if (ldValid) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (word_done) begin
          if (mode_q == SCAN_MODE_READ) begin
            next_state = DELIVER;
          end else if (last_word) begin
            next_state = DONE;
          end else begin
            next_state = FETCH;
          end
        end
      end
      DELIVER: begin
        busy    = 1'b1;
        rdValid = 1'b1;
        if (rdReady) begin
          next_state = last_word ? DONE : SHIFT;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (abort_hit) begin
      next_state = IDLE;
      done       = 1'b0;
      rdValid    = 1'b0;
      ldReady    = 1'b0;
    end
  end

  // Per-pass bookkeeping: latched mode, word index and the sticky abort flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= SCAN_MODE_READ;
      word_cnt <= '0;
      aborted  <= 1'b0;
    end else if (accept) begin
      mode_q   <= mode;
      word_cnt <= '0;
      aborted  <= 1'b0;
    end else begin
      if (abort_hit) begin
        aborted <= 1'b1;
      end
      if (word_step) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // Publish a completed read word; it stays put while the host stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdData <= '0;
    end else if ((state == SHIFT) && word_done && (mode_q == SCAN_MODE_READ)) begin
      rdData <= cap_word;
    end
  end

`ifdef SCAN_PARITY_EN
  // Parity of the published word, registered alongside rdData
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdParity <= 1'b0;
    end else if ((state == SHIFT) && word_done && (mode_q == SCAN_MODE_READ)) begin
      rdParity <= ^cap_word;
    end
  end

  // Sticky flag for a host word whose parity disagrees with ldParity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ldParErr <= 1'b0;
    end else if (accept) begin
      ldParErr <= 1'b0;
    end else if (ld_take && ((^ldData) != ldParity)) begin
      ldParErr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_scan_ctrl.sv
// Self-checking bench for reg_scan_ctrl with SIZE=8, WIDTH=32. A behavioural
// register file sits on the scan port; read words are predicted into a
// scoreboard queue when a pass is started and compared as the host accepts them.

`timescale 1ns/1ps

module tb_reg_scan_ctrl;

  localparam int SZ = 8;
  localparam int WD = 32;
  localparam int NB = SZ * WD;

  logic          clk;
  logic          rst;
  logic          start;
  logic          mode;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [WD-1:0] rdData;
  logic          rdValid;
  logic          rdReady;
  logic [WD-1:0] ldData;
  logic          ldValid;
  logic          ldReady;
  logic          sClock;
  logic          sEnable;
  logic          sIn;
  logic          sOut;
`ifdef SCAN_PARITY_EN
  logic          rdParity;
  logic          ldParity;
  logic          ldParErr;
`endif

  int num_checks = 0;
  int num_errors = 0;
  int done_cnt   = 0;
  int rx_cnt     = 0;

  logic [WD-1:0] exp_q[$];
  logic [WD-1:0] model_words [SZ];

  logic [NB-1:0] file_bits;
  logic [NB-1:0] init_bits;
  logic [7:0]    ptr;
  logic          tgt_init;

  reg_scan_ctrl #(.SIZE(SZ), .WIDTH(WD)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .rdData   (rdData),
    .rdValid  (rdValid),
    .rdReady  (rdReady),
    .ldData   (ldData),
    .ldValid  (ldValid),
    .ldReady  (ldReady),
    .sClock   (sClock),
    .sEnable  (sEnable),
    .sIn      (sIn),
    .sOut     (sOut)
`ifdef SCAN_PARITY_EN
    ,
    .rdParity (rdParity),
    .ldParity (ldParity),
    .ldParErr (ldParErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: current bit on sOut, rewritten and advanced on each scan clock rise
  assign sOut = file_bits[ptr];
  always @(posedge sClock or posedge tgt_init) begin
    if (tgt_init) begin
      file_bits <= init_bits;
      ptr       <= '0;
    end else if (sEnable) begin
      file_bits[ptr] <= sIn;
      ptr            <= ptr + 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    num_checks++;
    if (got !== expv) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [63:0] outs();
    return {24'h0, busy, done, aborted, rdValid, ldReady, sClock, sEnable, sIn, rdData};
  endfunction

  // Host side monitor: count done pulses and score accepted read words
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rdValid && rdReady) begin
      if (exp_q.size() == 0) begin
        checkOutput("extra_word", 64'(exp_q.size()), 64'd1);
      end else begin
        checkOutput($sformatf("rd_word%0d", rx_cnt % SZ), 64'(rdData), 64'(exp_q.pop_front()));
        rx_cnt++;
      end
    end
  end

  task automatic init_target(input logic [WD-1:0] base);
    for (int i = 0; i < SZ; i++) begin
      model_words[i] = base + WD'(i);
      init_bits[i*WD +: WD] = base + WD'(i);
    end
    tgt_init = 1'b1;
    #1 tgt_init = 1'b0;
  endtask

  task automatic push_expected();
    for (int i = 0; i < SZ; i++) exp_q.push_back(model_words[i]);
  endtask

  task automatic check_file();
    for (int i = 0; i < SZ; i++)
      checkOutput($sformatf("file_w%0d", i), 64'(file_bits[i*WD +: WD]), 64'(model_words[i]));
    checkOutput("ptr_aligned", 64'(ptr), 64'd0);
  endtask

  // One-cycle start request with the given mode and abort level
  task automatic applyStimulus(input logic m, input logic ab);
    start = 1'b1;
    mode  = m;
    abort = ab;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    int n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        checkOutput("busy_at_done", 64'(busy), 64'd0);
      end
      n++;
    end
    if (!seen) checkOutput("done_timeout", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_read_pass(input string tag);
    int d0 = done_cnt;
    push_expected();
    applyStimulus(1'b0, 1'b0);
    wait_done(1500);
    checkOutput({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    checkOutput({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check_file();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int r0;
    int n;
    rst = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    rdReady = 1'b1; ldData = '0; ldValid = 1'b0; tgt_init = 1'b0;
`ifdef SCAN_PARITY_EN
    ldParity = 1'b0;
`endif
    init_target(32'h0);
    #23;
    checkOutput("reset_outs", outs(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] read pass with preserve");
    init_target(32'h1000_0000);
    run_read_pass("read1");

    $display("[TB] abort while idle is ignored");
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("idle_abort", {62'd0, aborted, busy}, 64'd0);

    $display("[TB] load pass");
    d0 = done_cnt;
    r0 = rx_cnt;
    for (int i = 0; i < SZ; i++) model_words[i] = 32'hA5A5_0000 + WD'(i);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < SZ; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ldValid = 1'b1;
      ldData  = model_words[i];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ldReady && n < 200);
      if (!ldReady) checkOutput("ld_timeout", 64'(ldReady), 64'd1);
      @(posedge clk);
      #1;
      ldValid = 1'b0;
      ldData  = '0;
    end
    wait_done(1000);
    checkOutput("load_done_count", 64'(done_cnt - d0), 64'd1);
    checkOutput("load_no_rd", 64'(rx_cnt - r0), 64'd0);
    check_file();
    run_read_pass("read2");

    $display("[TB] backpressure on word 3, start while busy");
    init_target(32'hC0DE_0000);
    d0 = done_cnt;
    r0 = rx_cnt;
    push_expected();
    applyStimulus(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; mode = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mode = 1'b0;
    n = 0;
    while (rx_cnt != r0 + 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("words_before_stall", 64'(rx_cnt - r0), 64'd3);
    @(posedge clk);
    #1 rdReady = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdValid && n < 200);
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("stall_c%0d", c), {29'd0, rdValid, sClock, sEnable, rdData},
                  {29'd0, 1'b1, 1'b0, 1'b0, model_words[3]});
      @(negedge clk);
    end
    @(posedge clk);
    #1 rdReady = 1'b1;
    wait_done(1500);
    checkOutput("bp_done_count", 64'(done_cnt - d0), 64'd1);
    checkOutput("bp_drained", 64'(exp_q.size()), 64'd0);
    check_file();

    $display("[TB] abort during bit 17 of word 2");
    init_target(32'h2000_0000);
    d0 = done_cnt;
    r0 = rx_cnt;
    push_expected();
    applyStimulus(1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ptr == 8'd81 && sEnable && !sClock) && n < 1000);
    checkOutput("reach_bit17", 64'(ptr), 64'd81);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abort_outs", {59'd0, sEnable, sClock, busy, rdValid, aborted}, 64'd1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 64'(done_cnt - d0), 64'd0);
    checkOutput("abort_words", 64'(rx_cnt - r0), 64'd2);
    checkOutput("abort_sticky", 64'(aborted), 64'd1);
    exp_q.delete();

    $display("[TB] start with simultaneous abort after re-initialising the file");
    init_target(32'h3000_0000);
    d0 = done_cnt;
    push_expected();
    applyStimulus(1'b0, 1'b1);
    checkOutput("start_abort_accept", {62'd0, busy, aborted}, 64'd2);
    wait_done(1500);
    checkOutput("restart_done_count", 64'(done_cnt - d0), 64'd1);
    checkOutput("restart_drained", 64'(exp_q.size()), 64'd0);
    check_file();

    $display("[TB] asynchronous reset mid-pass");
    init_target(32'h4000_0000);
    push_expected();
    applyStimulus(1'b0, 1'b0);
    repeat (100) @(posedge clk);
    #3 rst = 1'b0;
    #1 checkOutput("async_reset_outs", outs(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    init_target(32'h5000_0000);
    run_read_pass("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
